// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done request bus between the lab top-level and the serial adder.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );

endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit combinational full adder shared by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out,
  output logic s
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: feeds operands LSB-first through one full adder, one bit per clock.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   sumsh_q, sumsh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sumsh_next;

  fulladder u_fa (
    .a     (sha_q[0]),
    .b     (shb_q[0]),
    .c_in  (carry_q),
    .c_out (fa_co),
    .s     (fa_s)
  );

  // Adder sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign sumsh_next = WIDTH'({fa_s, sumsh_q} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sumsh_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sumsh_q <= sumsh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sumsh_d = sumsh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sha_d   = bus.a;
          shb_d   = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          sumsh_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        sumsh_d = sumsh_next;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        busy_d  = 1'b1;
        // Last bit: carry_q is still the carry into the MSB
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          sum_d   = sumsh_next;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nvec  = 0;
  int   nerr  = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum with carry, and signed result range check for overflow
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W:0] full, output logic ovf);
    int s;
    full = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    s    = int'($signed(a)) + int'($signed(b)) + int'(c);
    ovf  = (s > 127) || (s < -128);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input string tag);
    logic [W:0] full;
    logic       ovf;
    int         busy_cnt;
    bit         seen;
    busy_cnt = 0;
    seen     = 1'b0;
    model(a, b, c, full, ovf);
    bus.a = a; bus.b = b; bus.c_in = c; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.c_in = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(full[W-1:0]));
      chk({tag, "_cout"}, 32'(bus.c_out), 32'(full[W]));
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
      tick();
      chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [W:0] full;
    logic       ovf;
    int         dcnt;
    int         idx[$];
    int         busy_cnt;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.c_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();

    run_op(8'h3C, 8'h5A, 1'b0, "d3c5a");
    run_op(8'hFF, 8'h01, 1'b0, "dff01");
    run_op(8'h7F, 8'h00, 1'b1, "d7f00");
    run_op(8'h80, 8'h80, 1'b0, "d8080");
    run_op(8'hFF, 8'hFF, 1'b1, "dffff");

    // Start pulse in mid-run must be ignored
    bus.a = 8'h10; bus.b = 8'h20; bus.c_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        dcnt++;
        chk("ign_sum", 32'(bus.sum), 32'h30);
      end
      tick();
    end
    chk("ign_done_count", 32'(dcnt), 32'd1);

    // Reset in the middle of a run discards it
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    dcnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dcnt++;
      if (bus.busy) busy_cnt++;
      tick();
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);
    chk("mid_rst_idle", 32'(busy_cnt), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, "post_rst");

    // Start held high: runs back to back
    bus.a = 8'h05; bus.b = 8'h03; bus.c_in = 1'b0; bus.start = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        idx.push_back(i);
        chk("b2b_sum", 32'(bus.sum), 32'h08);
        chk("b2b_excl", 32'(bus.busy), 32'd0);
      end
      tick();
    end
    bus.start = 1'b0;
    chk("b2b_pulses", 32'(idx.size()), 32'd3);
    if (idx.size() == 3) begin
      chk("b2b_first", 32'(idx[0]), 32'(W));
      chk("b2b_period1", 32'(idx[1] - idx[0]), 32'(W + 2));
      chk("b2b_period2", 32'(idx[2] - idx[1]), 32'(W + 2));
    end
    chk("b2b_busy_total", 32'(busy_cnt), 32'(3 * W + 2));
    for (int i = 0; i < 12; i++) tick();

    // Reset dominates a held start
    reset = 1'b1;
    bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
    tick();
    dcnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dcnt++;
      if (bus.busy) busy_cnt++;
      tick();
    end
    chk("rst_start_busy", 32'(busy_cnt), 32'd0);
    chk("rst_start_done", 32'(dcnt), 32'd0);
    chk("rst_start_sum", 32'(bus.sum), 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, "rnd");
    end

    model(8'h3C, 8'h5A, 1'b0, full, ovf);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in on a start/done handshake.
- Feeds them LSB-first through a single 1-bit fulladder instance, one bit per clock.
- Returns the WIDTH-bit sum, carry-out and signed overflow.
- Trades WIDTH cycles of latency for one adder cell; sits between a lab top-level (switches/FSM) and the shared fulladder.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered sum; holds until next accepted start.
- c_out  output  1  registered final carry.
- overflow  output  1  registered signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain; reset is synchronous and active-high (port reset, clock clk).
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, counter=0, carry reg=0, shift regs=0.
- IDLE:
  - start=1 at an edge → capture a→sha, b→shb, c_in→carry, clear counter, clear sum shift reg, go RUN.
  - start=0 → stay in IDLE.
- RUN, one edge per bit:
  - Fulladder inputs are sha[0], shb[0], carry.
  - sha and shb shift right by 1.
  - Fulladder s shifts into sum shift reg at MSB (shift right).
  - carry ← fulladder c_out.
  - counter increments.
  - When counter==WIDTH-1: latch carry-before-update as c_msb_in, go DONE.
- DONE (exactly 1 cycle):
  - done=1; sum, c_out, overflow registers loaded on entry and valid.
  - Next edge → IDLE unconditionally.
- Latency: done high in the cycle after WIDTH+1 edges following the start-sampling edge. Next start can be accepted at the edge leaving DONE+1, i.e. in IDLE.
- start while busy or done=1: ignored, no effect on operands or result.
- Operand changes on a/b/c_in after acceptance: no effect.
- Reset asserted mid-RUN: next edge forces the reset values above, with no done pulse and the partial result discarded. Reset has priority over start at the same edge.
- Arithmetic: {c_out,sum} = a + b + c_in modulo 2^(WIDTH+1). overflow = c_msb_in ^ c_out.
- busy and done are never both 1.

Decomposition:
- Shared package/include holds the state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default WIDTH.
- One sub-module: the existing fulladder (ports a, b, c_in, c_out, s), instantiated once, purely combinational.
- All sequencing, shifting and counting live in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, c_in=0, start 1 cycle → busy high 8 cycles, done pulse at edge 9; sum=8'h96, c_out=0, overflow=1.
- a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1, overflow=0. a=8'h7F, b=8'h00, c_in=1 → sum=8'h80, c_out=0, overflow=1.
- Start a=8'h10, b=8'h20. Pulse start again with a=8'hFF, b=8'hFF at cycle 3 of RUN → ignored; result sum=8'h30, single done pulse.
- Start a=8'hAA, b=8'h55. Assert reset at RUN cycle 4 → next cycle busy=0, done=0, sum=0, state IDLE; no done for 12 cycles. New start a=8'h01, b=8'h01 → sum=8'h02.
- Back-to-back: hold start high continuously with a=8'h05, b=8'h03 → done pulses every WIDTH+2 cycles, sum=8'h08 each time, busy low exactly 1 cycle (IDLE) between runs plus the DONE cycle.
- Reset held with start=1 → no capture; outputs stay at reset values until reset deasserts.
